// File: rtl/jtag_master_ctrl_if.sv
// jtag_master_ctrl_if: command/response handshake bundle between a command source and jtag_master_ctrl
interface jtag_master_ctrl_if #(
  parameter int MAX_LEN = 64
);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [6:0] cmd_len;
  logic [MAX_LEN-1:0] cmd_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [MAX_LEN-1:0] rsp_data;
  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/jtag_master_ctrl.sv
// jtag_master_ctrl: 1149.1 TAP sequencer driven by a command/response handshake; JTAG_MASTER_IDLE_PAD_EN adds RTI padding after shifts
module jtag_master_ctrl #(
  parameter int TCK_DIV = 2,
  parameter int MAX_LEN = 64
`ifdef JTAG_MASTER_IDLE_PAD_EN
  , parameter int PAD_CYCLES = 4
`endif
) (
  input  logic clk,
  input  logic reset_n,
  jtag_master_ctrl_if.slave bus,
  output logic tck,
  output logic tms,
  output logic tdi,
  input  logic tdo,
  output logic busy
);
  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TCK_DIV - 1);
  localparam logic [6:0] LEN_MAX = 7'(MAX_LEN);
  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR = 2'd1;
  localparam logic [1:0] OP_DR = 2'd2;
  typedef enum logic [2:0] {
    INIT, IDLE, HDR, SHIFT, TAIL,
`ifdef JTAG_MASTER_IDLE_PAD_EN
    PAD,
`endif
    RESP
  } state_e;
  state_e state, state_d;
  logic [6:0] cnt, cnt_d, last_idx, len_q, len_n;
  logic [1:0] op_q, op_n;
  logic [MAX_LEN-1:0] data_q, data_n, rsp_q;
  logic [DW-1:0] div;
  logic run, tick, rise, fall, accept, last, tms_d, tdi_d;
  // cnt indexes the current tck within the current state; tck only runs outside IDLE/RESP
  assign run = state != IDLE && state != RESP;
  assign tick = run && div == DIV_LAST;
  assign rise = tick && !tck;
  assign fall = tick && tck;
  assign accept = state == IDLE && bus.cmd_valid;
  assign op_n = accept ? bus.cmd_op : op_q;
  assign len_n = accept ? ((bus.cmd_len > LEN_MAX) ? LEN_MAX : bus.cmd_len) : len_q;
  assign data_n = accept ? bus.cmd_data : data_q;
  assign bus.rsp_data = rsp_q;
  // state register; reset lands in INIT so the TAP is walked to RTI after every reset
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INIT;
      cnt <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
    end
  // next step: advance on each falling tck edge, or on handshakes outside the tck sequence
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    last_idx = 7'd1;
    case (state)
      INIT: last_idx = 7'd5;
      HDR: last_idx = (op_q == OP_IR) ? 7'd3 : (op_q == OP_DR) ? 7'd2 : (op_q == OP_RESET) ? 7'd5 : len_q - 7'd1;
      SHIFT: last_idx = len_q - 7'd1;
`ifdef JTAG_MASTER_IDLE_PAD_EN
      PAD: last_idx = 7'(PAD_CYCLES - 1);
`endif
      default: ;
    endcase
    last = cnt == last_idx;
    case (state)
      IDLE: if (accept) begin
        state_d = (op_n != OP_RESET && len_n == 7'd0) ? RESP : HDR;
        cnt_d = '0;
      end
      RESP: if (bus.rsp_ready) state_d = IDLE;
      default: if (fall) begin
        cnt_d = last ? 7'd0 : cnt + 7'd1;
        if (last)
          case (state)
            INIT: state_d = IDLE;
            HDR: state_d = (op_q == OP_IR || op_q == OP_DR) ? SHIFT : RESP;
            SHIFT: state_d = TAIL;
`ifdef JTAG_MASTER_IDLE_PAD_EN
            TAIL: state_d = PAD;
`endif
            default: state_d = RESP;
          endcase
      end
    endcase
  end
  // outputs; tms/tdi are precomputed from the next step so they register exactly when tck falls or a sequence starts
  always_comb begin
    bus.cmd_ready = state == IDLE;
    bus.rsp_valid = state == RESP;
    busy = state != IDLE;
    tms_d = 1'b0;
    case (state_d)
      INIT: tms_d = cnt_d < 7'd5;
      HDR: tms_d = (op_n == OP_RESET) ? cnt_d < 7'd5 : (op_n == OP_IR) ? cnt_d < 7'd2 : (op_n == OP_DR) ? cnt_d == 7'd0 : 1'b0;
      SHIFT: tms_d = cnt_d == len_n - 7'd1;
      TAIL: tms_d = cnt_d == 7'd0;
      default: ;
    endcase
    tdi_d = (state_d == SHIFT) ? data_n[cnt_d[IW-1:0]] : 1'b0;
  end
  // tck divider, pin registers, command latch and tdo capture on rising tck
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div <= '0;
      tck <= 1'b0;
      tms <= 1'b1;
      tdi <= 1'b0;
      op_q <= '0;
      len_q <= '0;
      data_q <= '0;
      rsp_q <= '0;
    end else begin
      div <= (!run || tick) ? '0 : div + 1'b1;
      tck <= tck ^ tick;
      tms <= tms_d;
      tdi <= tdi_d;
      op_q <= op_n;
      len_q <= len_n;
      data_q <= data_n;
      if (accept) rsp_q <= '0;
      else if (state == SHIFT && rise) rsp_q[cnt[IW-1:0]] <= tdo;
    end
endmodule

// File: doc/jtag_master_ctrl.md
Name: jtag_master_ctrl

Overview:
- RTL JTAG master that sequences a 1149.1 TAP from a simple command/response handshake.
- Generates tck, tms and tdi, and captures tdo; the synthesizable counterpart to the testbench JTAG stimulus.
- Sits between the on-chip or host command source and the HICANN TAP.
- Between commands the TAP is always parked in Run-Test/Idle (RTI).

Parameters:
TCK_DIV, 2, clk cycles per tck half-period (>=1); tck period = 2*TCK_DIV clk
MAX_LEN, 64, maximum shift length in bits; width of cmd_data/rsp_data
PAD_CYCLES, 4, RTI tck cycles appended after shifts (optional feature only)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_op  in  2  0=TAP_RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE
cmd_len  in  7  shift bits (1..MAX_LEN) or IDLE tck count
cmd_data  in  MAX_LEN  tdi bits, LSB shifted first
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready
rsp_data  out  MAX_LEN  captured tdo, bit i = i-th shifted bit, upper bits 0
tck  out  1  JTAG clock
tms  out  1  JTAG mode select
tdi  out  1  JTAG data to target
tdo  in  1  JTAG data from target
busy  out  1  high whenever not in IDLE state

Behaviour:
- Reset values: tck=0, tms=1, tdi=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=1.
- Reset is asynchronous. Asserting it mid-operation aborts immediately; any in-flight command and response are dropped.
- tck timing:
  - tck toggles every TCK_DIV clk while a sequence runs, and idles low otherwise.
  - tms and tdi update in the clk where tck falls, or at sequence start with tck low.
  - tdo is sampled in the clk where tck rises.
- States: INIT, IDLE, HDR, SHIFT, TAIL, PAD, RESP.
- INIT (entered after reset release):
  - 5 tck with tms=1, then 1 tck with tms=0, which lands the TAP in RTI.
  - Then go to IDLE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On handshake, latch op/len/data, clear rsp_data, deassert cmd_ready in the next clk, and go to HDR.
- HDR (tms header sequence):
  - SHIFT_IR: tms 1,1,0,0.
  - SHIFT_DR: tms 1,0,0.
  - TAP_RESET: tms 1,1,1,1,1,0, then go to RESP.
  - IDLE op: cmd_len tck with tms=0, then go to RESP.
- SHIFT:
  - One tck per bit, with tdi=data[i].
  - tms=0 for bits 0..len-2; tms=1 on bit len-1 (Exit1).
  - Capture tdo into rsp_data[i].
- TAIL:
  - tms 1 (Update), then tms 0 (RTI).
  - Go to PAD if the feature is enabled, else to RESP.
- RESP:
  - rsp_valid=1 until rsp_ready; rsp_data is held stable.
  - cmd_ready stays 0 until the response is consumed, then return to IDLE.
  - Accepting the next command in the same clk as the response handshake is not allowed; it happens one clk later.
- Boundary cases:
  - Shift with cmd_len=0: no tck; go directly to RESP with rsp_data=0.
  - IDLE op with cmd_len=0: same as above.
  - cmd_len>MAX_LEN: clamp to MAX_LEN.
  - cmd_len=1: the single bit carries tms=1.
  - cmd_op and cmd_data are ignored unless a handshake occurs.
- Latency: the first tck rising edge occurs TCK_DIV clk after the command handshake.
- TAP_RESET and IDLE responses return rsp_data=0.

Optional Feature:
- Macro: JTAG_MASTER_IDLE_PAD_EN.
- When defined:
  - After TAIL of SHIFT_IR/SHIFT_DR, go to PAD and issue PAD_CYCLES extra tck with tms=0 and tdi=0 before RESP.
  - busy stays high during PAD.
- When undefined:
  - PAD state and PAD_CYCLES logic are absent; TAIL goes directly to RESP.

Test Plan:
- Reset release, TCK_DIV=2 -> 6 tck pulses of 4 clk each, with tms sampled 1,1,1,1,1,0 at rising edges; then cmd_ready=1 and busy=0.
- SHIFT_IR, len=6, data=6'h2A, tdo looped to tdi:
  - tms at rising edges 1,1,0,0,0,0,0,0,0,1,1,0.
  - tdi on shift bits 0,1,0,1,0,1.
  - rsp_data=0x2A.
- SHIFT_DR, len=64, data=64'hDEADBEEF_CAFEF00D, with loopback -> 3+64+2=69 tck; rsp_data=64'hDEADBEEF_CAFEF00D.
- IDLE op, len=10, followed by TAP_RESET:
  - IDLE: 10 tck with tms=0, rsp_data=0.
  - TAP_RESET: tms 1,1,1,1,1,0.
- rsp_ready held low for 20 clk after a shift -> rsp_valid and rsp_data stable, cmd_ready=0, tck idle low; accept resumes 1 clk after the handshake.
- reset_n pulsed low during bit 30 of a 64-bit DR shift -> outputs at reset values immediately and no rsp_valid; INIT sequence repeats after release.
- With JTAG_MASTER_IDLE_PAD_EN and PAD_CYCLES=4 -> 4 extra tms=0 tck before rsp_valid.
